// File: rtl/mrq_pkg.sv
// rtl/mrq_pkg.sv - shared constants and FSM encoding for the memory request queue
package mrq_pkg;

    localparam int MRQ_AW = 4;
    localparam int MRQ_DW = 8;

    localparam int MRQ_RW_W = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mrq_state_t;

    // Queue entries are packed as {rw, addr, wdata}, rw in the MSB.
    function automatic int mrq_req_w(input int aw, input int dw);
        return MRQ_RW_W + aw + dw;
    endfunction

endpackage

// File: rtl/mrq_fifo.sv
// rtl/mrq_fifo.sv - DEPTH x W synchronous FIFO holding queued requests
module mrq_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 13
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [PW:0]  wr_ptr;
    logic [PW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    // Full is judged before this cycle's pop, so a pop never frees a slot in the same edge.
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= wdata;
    end

endmodule

// File: rtl/mem_request_queue.sv
// rtl/mem_request_queue.sv - request FIFO and issue FSM in front of the SRAM controller
// Optional abort on missing mc_done is enabled with `define MRQ_TIMEOUT_EN.
module mem_request_queue
    import mrq_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int AW      = MRQ_AW,
    parameter int DW      = MRQ_DW,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_rw,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    output logic          rsp_rw,
    output logic [AW-1:0] rsp_addr,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          mc_start,
    output logic          mc_rw,
    output logic [AW-1:0] mc_addr,
    output logic [DW-1:0] mc_data_in,
    input  logic [DW-1:0] mc_data_out,
    input  logic          mc_done
);

    localparam int RW = mrq_req_w(AW, DW);

    mrq_state_t    state, state_n;
    logic [RW-1:0] head;
    logic          full, empty, pop;

    logic          start_n, rw_n, rsp_valid_n, rsp_rw_n;
    logic [AW-1:0] addr_n, rsp_addr_n;
    logic [DW-1:0] data_n, rsp_rdata_n;

    mrq_fifo #(.DEPTH(DEPTH), .W(RW)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (req_valid),
        .wdata ({req_rw, req_addr, req_wdata}),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign req_ready = !full;

`ifdef MRQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo, tmo_n;
    logic          rsp_err_q, rsp_err_n;
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    always_comb begin
        state_n     = state;
        pop         = 1'b0;
        start_n     = 1'b0;
        rw_n        = mc_rw;
        addr_n      = mc_addr;
        data_n      = mc_data_in;
        rsp_valid_n = 1'b0;
        rsp_rw_n    = rsp_rw;
        rsp_addr_n  = rsp_addr;
        rsp_rdata_n = rsp_rdata;
`ifdef MRQ_TIMEOUT_EN
        tmo_n       = tmo;
        rsp_err_n   = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    rw_n    = head[RW-1];
                    addr_n  = head[RW-2 -: AW];
                    data_n  = head[DW-1:0];
                    start_n = 1'b1;
                    state_n = ST_WAIT;
`ifdef MRQ_TIMEOUT_EN
                    tmo_n   = '0;
`endif
                end
            end
            ST_WAIT: begin
                if (mc_done) begin
                    rsp_valid_n = 1'b1;
                    rsp_rw_n    = mc_rw;
                    rsp_addr_n  = mc_addr;
                    rsp_rdata_n = mc_rw ? mc_data_out : '0;
                    state_n     = ST_IDLE;
                end
`ifdef MRQ_TIMEOUT_EN
                else if (tmo == TW'(TIMEOUT - 1)) begin
                    rsp_valid_n = 1'b1;
                    rsp_rw_n    = mc_rw;
                    rsp_addr_n  = mc_addr;
                    rsp_rdata_n = '0;
                    rsp_err_n   = 1'b1;
                    state_n     = ST_IDLE;
                end else begin
                    tmo_n = tmo + 1'b1;
                end
`endif
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            mc_start   <= 1'b0;
            mc_rw      <= 1'b0;
            mc_addr    <= '0;
            mc_data_in <= '0;
            rsp_valid  <= 1'b0;
            rsp_rw     <= 1'b0;
            rsp_addr   <= '0;
            rsp_rdata  <= '0;
`ifdef MRQ_TIMEOUT_EN
            tmo        <= '0;
            rsp_err_q  <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            mc_start   <= start_n;
            mc_rw      <= rw_n;
            mc_addr    <= addr_n;
            mc_data_in <= data_n;
            rsp_valid  <= rsp_valid_n;
            rsp_rw     <= rsp_rw_n;
            rsp_addr   <= rsp_addr_n;
            rsp_rdata  <= rsp_rdata_n;
`ifdef MRQ_TIMEOUT_EN
            tmo        <= tmo_n;
            rsp_err_q  <= rsp_err_n;
`endif
        end
    end

endmodule

// File: tb/tb_mem_request_queue.sv
// tb/tb_mem_request_queue.sv - directed self-checking bench for mem_request_queue
module tb_mem_request_queue;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_ready, req_rw;
    logic [3:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid, rsp_rw, rsp_err;
    logic [3:0] rsp_addr;
    logic [7:0] rsp_rdata;
    logic       mc_start, mc_rw, mc_done;
    logic [3:0] mc_addr;
    logic [7:0] mc_data_in, mc_data_out;

    mem_request_queue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_rw      (req_rw),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rw      (rsp_rw),
        .rsp_addr    (rsp_addr),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .mc_start    (mc_start),
        .mc_rw       (mc_rw),
        .mc_addr     (mc_addr),
        .mc_data_in  (mc_data_in),
        .mc_data_out (mc_data_out),
        .mc_done     (mc_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Controller model: start sampled on edge S, done high from edge S+2 for one cycle.
    logic       ctrl_en    = 1'b1;
    logic       model_done = 1'b0;
    logic       stray_done = 1'b0;
    logic [1:0] mcnt       = 2'd0;
    logic [7:0] mem [16]   = '{default: 8'h00};

    assign mc_done     = model_done | stray_done;
    assign mc_data_out = mem[mc_addr];

    always @(posedge clk) begin
        model_done <= 1'b0;
        if (ctrl_en && mc_start) begin
            mcnt <= 2'd1;
        end else if (mcnt == 2'd1) begin
            mcnt <= 2'd2;
        end else if (mcnt == 2'd2) begin
            mcnt       <= 2'd0;
            model_done <= 1'b1;
            if (!mc_rw) mem[mc_addr] <= mc_data_in;
        end
    end

    typedef struct {
        int         c;
        logic       rw;
        logic [3:0] addr;
        logic [7:0] rdata;
        logic       err;
    } rsp_t;

    rsp_t       rsp_q[$];
    int         start_cnt = 0;
    int         start_cyc = 0;
    logic       start_rw;
    logic [3:0] start_addr;
    logic [7:0] start_data;

    always @(negedge clk) begin
        rsp_t r;
        if (rsp_valid) begin
            r.c     = cyc;
            r.rw    = rsp_rw;
            r.addr  = rsp_addr;
            r.rdata = rsp_rdata;
            r.err   = rsp_err;
            rsp_q.push_back(r);
        end
        if (mc_start) begin
            start_cnt  <= start_cnt + 1;
            start_cyc  <= cyc;
            start_rw   <= mc_rw;
            start_addr <= mc_addr;
            start_data <= mc_data_in;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_hold(input logic rw, input logic [3:0] addr, input logic [7:0] data,
                             output int acc);
        logic r;
        r         = 1'b0;
        acc       = -1;
        req_valid = 1'b1;
        req_rw    = rw;
        req_addr  = addr;
        req_wdata = data;
        for (int k = 0; k < 60; k++) begin
            r   = req_ready;
            acc = cyc + 1;
            tick();
            if (r) break;
        end
        check("push_accept", {31'd0, r}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t2, s0;
        int acc [6];

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_rw    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (2) tick();
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_mc_start",  {31'd0, mc_start},  32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_mc_addr",   {28'd0, mc_addr},   32'd0);
        check("rst_mc_data",   {24'd0, mc_data_in}, 32'd0);
        check("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
        rst_n = 1'b1;
        tick();

        // single write
        push_hold(1'b0, 4'd3, 8'hA5, t);
        req_valid = 1'b0;
        repeat (7) tick();
        check("w_start_cnt",  start_cnt, 1);
        check("w_start_cyc",  start_cyc, t + 1);
        check("w_start_addr", {28'd0, start_addr}, 32'd3);
        check("w_start_data", {24'd0, start_data}, 32'hA5);
        check("w_start_rw",   {31'd0, start_rw}, 32'd0);
        check("w_rsp_n",      rsp_q.size(), 1);
        if (rsp_q.size() >= 1) begin
            check("w_rsp_cyc",   rsp_q[0].c, t + 5);
            check("w_rsp_rw",    {31'd0, rsp_q[0].rw}, 32'd0);
            check("w_rsp_addr",  {28'd0, rsp_q[0].addr}, 32'd3);
            check("w_rsp_rdata", {24'd0, rsp_q[0].rdata}, 32'd0);
            check("w_rsp_err",   {31'd0, rsp_q[0].err}, 32'd0);
        end
        rsp_q.delete();

        // write then read back
        push_hold(1'b0, 4'd7, 8'h5A, t);
        push_hold(1'b1, 4'd7, 8'h00, t2);
        req_valid = 1'b0;
        repeat (14) tick();
        check("wr_rsp_n", rsp_q.size(), 2);
        if (rsp_q.size() >= 2) begin
            check("rd_rsp_cyc",   rsp_q[1].c, t + 10);
            check("rd_rsp_rw",    {31'd0, rsp_q[1].rw}, 32'd1);
            check("rd_rsp_addr",  {28'd0, rsp_q[1].addr}, 32'd7);
            check("rd_rsp_rdata", {24'd0, rsp_q[1].rdata}, 32'h5A);
        end
        rsp_q.delete();

        // one in flight plus four queued fills the FIFO; sixth waits for a pop
        for (int i = 0; i < 5; i++) push_hold(1'b0, 4'(i + 1), 8'(8'h10 + i), acc[i]);
        check("full_ready", {31'd0, req_ready}, 32'd0);
        check("full_acc4",  acc[4], acc[0] + 4);
        push_hold(1'b0, 4'd6, 8'h15, acc[5]);
        req_valid = 1'b0;
        check("held_acc", acc[5], acc[0] + 7);
        repeat (32) tick();
        check("burst_rsp_n", rsp_q.size(), 6);
        for (int k = 0; k < 6; k++) begin
            if (k < rsp_q.size()) begin
                check("burst_addr", {28'd0, rsp_q[k].addr}, 32'(k + 1));
                check("burst_cyc",  rsp_q[k].c, acc[0] + 5 + 5 * k);
            end
        end
        rsp_q.delete();

        // reset during WAIT discards in-flight and queued work
        s0 = start_cnt;
        push_hold(1'b1, 4'd9, 8'h00, t);
        push_hold(1'b1, 4'd10, 8'h00, t2);
        req_valid = 1'b0;
        check("pre_rst_addr", {28'd0, mc_addr}, 32'd9);
        rst_n = 1'b0;
        #1;
        check("mid_rst_addr",  {28'd0, mc_addr}, 32'd0);
        check("mid_rst_rw",    {31'd0, mc_rw}, 32'd0);
        check("mid_rst_ready", {31'd0, req_ready}, 32'd1);
        check("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (12) tick();
        check("post_rst_rsp_n", rsp_q.size(), 0);
        check("post_rst_start", start_cnt, s0 + 1);

        // stray done in IDLE with nothing queued
        s0 = start_cnt;
        stray_done = 1'b1;
        tick();
        stray_done = 1'b0;
        repeat (4) tick();
        check("stray_rsp_n", rsp_q.size(), 0);
        check("stray_start", start_cnt, s0);

`ifdef MRQ_TIMEOUT_EN
        ctrl_en = 1'b0;
        push_hold(1'b1, 4'd2, 8'h00, t);
        req_valid = 1'b0;
        repeat (20) tick();
        check("tmo_rsp_n", rsp_q.size(), 1);
        if (rsp_q.size() >= 1) begin
            check("tmo_cyc",   rsp_q[0].c, t + 16);
            check("tmo_err",   {31'd0, rsp_q[0].err}, 32'd1);
            check("tmo_rdata", {24'd0, rsp_q[0].rdata}, 32'd0);
        end
        rsp_q.delete();
        ctrl_en = 1'b1;
        push_hold(1'b1, 4'd7, 8'h00, t);
        req_valid = 1'b0;
        repeat (8) tick();
        check("after_tmo_n", rsp_q.size(), 1);
        if (rsp_q.size() >= 1) begin
            check("after_tmo_cyc",   rsp_q[0].c, t + 5);
            check("after_tmo_rdata", {24'd0, rsp_q[0].rdata}, 32'h5A);
            check("after_tmo_err",   {31'd0, rsp_q[0].err}, 32'd0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
